// File: rtl/ps2_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// ps2_cmd_sequencer
//
// Host-side sequencer for a PS/2 command transmitter/receiver pair. It accepts
// a command byte over a valid/ready handshake and starts the transmitter. It
// then waits for the device to answer with ACK (0xFA) or RESEND (0xFE). A
// resend request, a transmitter timeout or a missing answer causes the same
// byte to be sent again, up to MAX_RETRIES extra attempts. Success and final
// failure are each reported by a one-cycle pulse.
//
// Optional feature macro: PS2_SEQ_PARAM_BYTE_EN
//   When defined, the ports cmd_has_param/cmd_param are added. Two-byte
//   commands (command byte + parameter byte, e.g. 0xED LED set) are then
//   sequenced, and done pulses only after the parameter byte is ACKed.
//
// Parameters:
//   ACK_TIMEOUT  clk cycles to wait for a response byte after tx_sent
//   MAX_RETRIES  retransmissions allowed per byte after the first attempt
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   cmd_in         command byte to send
//   cmd_valid      command request
//   cmd_ready      high only in IDLE; transfer on cmd_valid && cmd_ready
//   cmd_has_param  (feature) command is followed by a parameter byte
//   cmd_param      (feature) parameter byte
//   tx_command     byte presented to the transmitter
//   tx_send        one-cycle transmitter start pulse
//   tx_sent        transmitter byte-sent pulse
//   tx_timeout     transmitter communication-timeout pulse
//   rx_byte        byte from the receiver
//   rx_byte_en     strobe qualifying rx_byte
//   done           one-cycle pulse: sequence acknowledged
//   fail           one-cycle pulse: retries exhausted
//   retry_cnt      retries used by the last or current byte (saturates at 3)
//   debug          state code: IDLE=0 SEND=1 WAIT_TX=2 WAIT_ACK=3 DONE=4 FAIL=5
// -----------------------------------------------------------------------------
module ps2_cmd_sequencer #(
  parameter int ACK_TIMEOUT = 100000,
  parameter int MAX_RETRIES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_in,
  input  logic       cmd_valid,
  output logic       cmd_ready,
`ifdef PS2_SEQ_PARAM_BYTE_EN
  input  logic       cmd_has_param,
  input  logic [7:0] cmd_param,
`endif
  output logic [7:0] tx_command,
  output logic       tx_send,
  input  logic       tx_sent,
  input  logic       tx_timeout,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_en,
  output logic       done,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [3:0] debug
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEND     = 3'd1;
  localparam logic [2:0] S_WAIT_TX  = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_FAIL     = 3'd5;

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;

  // The ACK counter holds values up to ACK_TIMEOUT, so it never wraps.
  localparam int CNT_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int RTRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0]  ACK_LAST    = CNT_W'(ACK_TIMEOUT);
  localparam logic [RTRY_W-1:0] RETRY_LIMIT = RTRY_W'(MAX_RETRIES);

  logic [2:0]        r_state;
  logic              r_cmd_ready;
  logic [7:0]        r_tx_command;
  logic              r_tx_send;
  logic              r_done;
  logic              r_fail;
  logic [1:0]        r_retry_cnt;
  logic [RTRY_W-1:0] r_retries;
  logic [CNT_W-1:0]  r_ack_cnt;

`ifdef PS2_SEQ_PARAM_BYTE_EN
  logic              r_has_param;
  logic [7:0]        r_param;
  logic              r_param_phase;
`endif

  logic w_in_tx;
  logic w_in_ack;
  logic w_byte_ack;
  logic w_byte_resend;
  logic w_ack_expired;
  logic w_retry_req;
  logic w_can_retry;
  logic w_next_param;

  assign w_in_tx       = (r_state == S_WAIT_TX);
  assign w_in_ack      = (r_state == S_WAIT_ACK);
  assign w_byte_ack    = w_in_ack && rx_byte_en && (rx_byte == BYTE_ACK);
  assign w_byte_resend = w_in_ack && rx_byte_en && (rx_byte == BYTE_RESEND);

  // Counter is cleared on entry to WAIT_ACK and counts every WAIT_ACK cycle,
  // so expiry lands on the (ACK_TIMEOUT+1)-th cycle there. An ACK/RESEND
  // byte on that same cycle takes priority; any other byte does not.
  assign w_ack_expired = w_in_ack && (r_ack_cnt == ACK_LAST) &&
                         !w_byte_ack && !w_byte_resend;

  // tx_timeout alone decides the WAIT_TX outcome when it coincides with tx_sent.
  assign w_retry_req = (w_in_tx && tx_timeout) || w_byte_resend || w_ack_expired;
  assign w_can_retry = (r_retries < RETRY_LIMIT);

`ifdef PS2_SEQ_PARAM_BYTE_EN
  assign w_next_param = r_has_param && !r_param_phase;
`else
  assign w_next_param = 1'b0;
`endif

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its peers, matching real flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b1;
      r_tx_command  <= 8'h00;
      r_tx_send     <= 1'b0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
      r_retry_cnt   <= 2'd0;
      r_retries     <= '0;
      r_ack_cnt     <= '0;
`ifdef PS2_SEQ_PARAM_BYTE_EN
      r_has_param   <= 1'b0;
      r_param       <= 8'h00;
      r_param_phase <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; only the transitions below raise them.
      r_tx_send <= 1'b0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;

      if (w_retry_req) begin
        if (w_can_retry) begin
          r_retries   <= r_retries + 1'b1;
          r_retry_cnt <= (r_retry_cnt == 2'd3) ? 2'd3 : r_retry_cnt + 2'd1;
          r_state     <= S_SEND;
          r_tx_send   <= 1'b1;
        end else begin
          r_state <= S_FAIL;
          r_fail  <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cmd_valid) begin
              r_tx_command  <= cmd_in;
              r_retries     <= '0;
              r_retry_cnt   <= 2'd0;
              r_ack_cnt     <= '0;
              r_cmd_ready   <= 1'b0;
              r_state       <= S_SEND;
              r_tx_send     <= 1'b1;
`ifdef PS2_SEQ_PARAM_BYTE_EN
              r_has_param   <= cmd_has_param;
              r_param       <= cmd_param;
              r_param_phase <= 1'b0;
`endif
            end
          end

          // tx_send was raised on the way in, so it lasts exactly this cycle.
          S_SEND: r_state <= S_WAIT_TX;

          S_WAIT_TX: begin
            if (tx_sent) begin
              r_ack_cnt <= '0;
              r_state   <= S_WAIT_ACK;
            end
          end

          S_WAIT_ACK: begin
            if (w_byte_ack) begin
              if (w_next_param) begin
                // Command byte accepted: the parameter byte gets its own
                // full retry budget, and a resend repeats only that byte.
`ifdef PS2_SEQ_PARAM_BYTE_EN
                r_tx_command  <= r_param;
                r_param_phase <= 1'b1;
`endif
                r_retries   <= '0;
                r_retry_cnt <= 2'd0;
                r_state     <= S_SEND;
                r_tx_send   <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_ack_cnt <= r_ack_cnt + 1'b1;
            end
          end

          S_DONE, S_FAIL: begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
          end

          default: begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign tx_command = r_tx_command;
  assign tx_send    = r_tx_send;
  assign done       = r_done;
  assign fail       = r_fail;
  assign retry_cnt  = r_retry_cnt;
  assign debug      = {1'b0, r_state};

endmodule
